pll_lock_monitor: RTL and testbench

- Sits directly downstream of the digital PLL.
- Consumes the PLL's per-cycle error code and phase word, and decides whether the loop is locked using windowed error counting and a hysteretic state machine.
- Emits a locked flag, per-window error statistics, a lead/lag frequency-bias hint, and a once-per-period tick derived from the phase MSB.
- The SWIPT link controller uses these to gate data recovery.

---
 rtl/pll_lock_monitor.sv | 212 +++++++++++++++++++++
 tb/tb_pll_lock_monitor.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_monitor.sv
// PLL lock monitor: windowed error counting with a hysteretic lock FSM,
// per-window error/bias statistics and a phase-period tick.
module pll_lock_monitor #(
  parameter int unsigned PHASE_BITS     = 32,
  parameter int unsigned WINDOW_LG      = 6,
  parameter int unsigned LOCK_THRESH    = 4,
  parameter int unsigned LOCK_WINDOWS   = 4,
  parameter int unsigned UNLOCK_WINDOWS = 2,
  parameter int unsigned HOLD_CYCLES    = 256
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  enable,
  input  logic [1:0]            error,
  input  logic [PHASE_BITS-1:0] phase,
  output logic                  locked,
  output logic [1:0]            lock_state,
  output logic [WINDOW_LG:0]    err_count,
  output logic [1:0]            freq_bias,
  output logic                  window_done,
  output logic                  cycle_tick
);

  localparam int unsigned ACC_W = WINDOW_LG + 1;
  localparam int unsigned GR_W  = $clog2(LOCK_WINDOWS + 1);
  localparam int unsigned BR_W  = $clog2(UNLOCK_WINDOWS + 1);
  localparam int unsigned HC_W  = $clog2(HOLD_CYCLES + 1);

  localparam logic [WINDOW_LG-1:0] WIN_LAST  = '1;
  localparam logic [ACC_W-1:0]     ACC_MAX   = ACC_W'(1 << WINDOW_LG);
  localparam logic [ACC_W-1:0]     THRESH_V  = ACC_W'(LOCK_THRESH);
  localparam logic [GR_W-1:0]      GOOD_LAST = GR_W'(LOCK_WINDOWS - 1);
  localparam logic [BR_W-1:0]      BAD_LAST  = BR_W'(UNLOCK_WINDOWS - 1);
  localparam logic [HC_W-1:0]      HOLD_V    = HC_W'(HOLD_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_ACQUIRE = 2'b01,
    ST_LOCKED  = 2'b10,
    ST_HOLD    = 2'b11
  } state_e;

  state_e               state_q, state_d;
  logic [WINDOW_LG-1:0] win_cnt_q, win_cnt_d;
  logic [ACC_W-1:0]     err_acc_q, err_acc_d;
  logic [ACC_W-1:0]     lead_acc_q, lead_acc_d;
  logic [ACC_W-1:0]     lag_acc_q, lag_acc_d;
  logic [GR_W-1:0]      good_run_q, good_run_d;
  logic [BR_W-1:0]      bad_run_q, bad_run_d;
  logic [HC_W-1:0]      hold_cnt_q, hold_cnt_d;
  logic [ACC_W-1:0]     err_count_q, err_count_d;
  logic [1:0]           freq_bias_q, freq_bias_d;
  logic                 window_done_q, window_done_d;
  logic                 locked_q, locked_d;
  logic                 prev_msb_q, prev_msb_d;
  logic                 cycle_tick_q, cycle_tick_d;

  logic [ACC_W-1:0] err_tot, lead_tot, lag_tot;
  logic             acc_en, win_close, win_good;
  logic             unused_phase;

  assign unused_phase = ^phase[PHASE_BITS-2:0];

  function automatic logic [ACC_W-1:0] sat_inc(input logic [ACC_W-1:0] v, input logic inc);
    return (inc && (v != ACC_MAX)) ? v + ACC_W'(1) : v;
  endfunction

  // Window totals include the current cycle's error code.
  assign err_tot   = sat_inc(err_acc_q,  error != 2'b00);
  assign lead_tot  = sat_inc(lead_acc_q, error == 2'b11);
  assign lag_tot   = sat_inc(lag_acc_q,  error == 2'b01);
  assign acc_en    = enable && ((state_q == ST_ACQUIRE) || (state_q == ST_LOCKED));
  assign win_close = acc_en && (win_cnt_q == WIN_LAST);
  assign win_good  = (err_tot <= THRESH_V);

  always_comb begin
    state_d       = state_q;
    win_cnt_d     = win_cnt_q;
    err_acc_d     = err_acc_q;
    lead_acc_d    = lead_acc_q;
    lag_acc_d     = lag_acc_q;
    good_run_d    = good_run_q;
    bad_run_d     = bad_run_q;
    hold_cnt_d    = hold_cnt_q;
    err_count_d   = err_count_q;
    freq_bias_d   = freq_bias_q;
    window_done_d = 1'b0;
    prev_msb_d    = phase[PHASE_BITS-1];
    cycle_tick_d  = phase[PHASE_BITS-1] && !prev_msb_q;

    if (acc_en) begin
      win_cnt_d  = win_cnt_q + WINDOW_LG'(1);
      err_acc_d  = err_tot;
      lead_acc_d = lead_tot;
      lag_acc_d  = lag_tot;
      if (win_close) begin
        err_count_d   = err_tot;
        freq_bias_d   = (lead_tot > lag_tot) ? 2'b11 :
                        (lag_tot > lead_tot) ? 2'b01 : 2'b00;
        window_done_d = 1'b1;
        win_cnt_d     = '0;
        err_acc_d     = '0;
        lead_acc_d    = '0;
        lag_acc_d     = '0;
      end
    end

    case (state_q)
      ST_IDLE: begin
        win_cnt_d  = '0;
        err_acc_d  = '0;
        lead_acc_d = '0;
        lag_acc_d  = '0;
        if (enable) begin
          state_d    = ST_ACQUIRE;
          good_run_d = '0;
          bad_run_d  = '0;
        end
      end
      ST_ACQUIRE: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (win_close) begin
          if (!win_good) begin
            good_run_d = '0;
          end else if (good_run_q == GOOD_LAST) begin
            state_d    = ST_LOCKED;
            good_run_d = '0;
            bad_run_d  = '0;
          end else begin
            good_run_d = good_run_q + GR_W'(1);
          end
        end
      end
      ST_LOCKED: begin
        // Dropping enable wins over a coinciding window end; statistics freeze.
        if (!enable) begin
          state_d    = ST_HOLD;
          hold_cnt_d = '0;
        end else if (win_close) begin
          if (win_good) begin
            bad_run_d = '0;
          end else if (bad_run_q == BAD_LAST) begin
            state_d    = ST_ACQUIRE;
            good_run_d = '0;
            bad_run_d  = '0;
          end else begin
            bad_run_d = bad_run_q + BR_W'(1);
          end
        end
      end
      ST_HOLD: begin
        if (enable) begin
          state_d    = ST_LOCKED;
          win_cnt_d  = '0;
          err_acc_d  = '0;
          lead_acc_d = '0;
          lag_acc_d  = '0;
          bad_run_d  = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + HC_W'(1);
          if (hold_cnt_d == HOLD_V) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    locked_d = (state_d == ST_LOCKED) || (state_d == ST_HOLD);
  end

  always_ff @(posedge clk) begin
    if (nrst) begin
      state_q       <= ST_IDLE;
      win_cnt_q     <= '0;
      err_acc_q     <= '0;
      lead_acc_q    <= '0;
      lag_acc_q     <= '0;
      good_run_q    <= '0;
      bad_run_q     <= '0;
      hold_cnt_q    <= '0;
      err_count_q   <= '0;
      freq_bias_q   <= '0;
      window_done_q <= 1'b0;
      locked_q      <= 1'b0;
      prev_msb_q    <= 1'b0;
      cycle_tick_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      win_cnt_q     <= win_cnt_d;
      err_acc_q     <= err_acc_d;
      lead_acc_q    <= lead_acc_d;
      lag_acc_q     <= lag_acc_d;
      good_run_q    <= good_run_d;
      bad_run_q     <= bad_run_d;
      hold_cnt_q    <= hold_cnt_d;
      err_count_q   <= err_count_d;
      freq_bias_q   <= freq_bias_d;
      window_done_q <= window_done_d;
      locked_q      <= locked_d;
      prev_msb_q    <= prev_msb_d;
      cycle_tick_q  <= cycle_tick_d;
    end
  end

  assign locked      = locked_q;
  assign lock_state  = state_q;
  assign err_count   = err_count_q;
  assign freq_bias   = freq_bias_q;
  assign window_done = window_done_q;
  assign cycle_tick  = cycle_tick_q;

endmodule

// File: tb/tb_pll_lock_monitor.sv
// Bench for pll_lock_monitor: directed table/sequence checks plus randomized
// traffic compared every cycle against a window-queue reference model.
module tb_pll_lock_monitor;

  logic        clk = 1'b0;
  logic        nrst;
  logic        enable;
  logic [1:0]  error;
  logic [31:0] phase;
  logic        locked;
  logic [1:0]  lock_state;
  logic [6:0]  err_count;
  logic [1:0]  freq_bias;
  logic        window_done;
  logic        cycle_tick;

  int n_checks = 0;
  int n_pass   = 0;

  pll_lock_monitor dut (
    .clk(clk), .nrst(nrst), .enable(enable), .error(error), .phase(phase),
    .locked(locked), .lock_state(lock_state), .err_count(err_count),
    .freq_bias(freq_bias), .window_done(window_done), .cycle_tick(cycle_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
    else n_pass++;
  endtask

  // Reference model: the window is a queue of error codes, statistics are
  // counted from it when it reaches 64 entries.
  int         m_state = 0;   // 0 idle, 1 acquire, 2 locked, 3 hold
  int         m_good = 0, m_bad = 0, m_hold = 0;
  int         m_ec = 0;
  logic [1:0] m_bias = 2'b00;
  logic       m_wd = 1'b0, m_locked = 1'b0, m_prev = 1'b0, m_tick = 1'b0;
  logic [1:0] m_win[$];

  always @(posedge clk) begin
    int tot, ld, lg;
    if (nrst) begin
      m_state = 0; m_good = 0; m_bad = 0; m_hold = 0; m_ec = 0;
      m_bias = 2'b00; m_wd = 1'b0; m_locked = 1'b0; m_prev = 1'b0; m_tick = 1'b0;
      m_win.delete();
    end else begin
      m_tick = phase[31] && !m_prev;
      m_prev = phase[31];
      m_wd   = 1'b0;
      if (m_state == 0) begin
        m_win.delete();
        if (enable) begin m_state = 1; m_good = 0; m_bad = 0; end
      end else if (m_state == 3) begin
        if (enable) begin m_state = 2; m_win.delete(); m_bad = 0; end
        else begin
          m_hold++;
          if (m_hold == 256) m_state = 0;
        end
      end else if (!enable) begin
        if (m_state == 1) m_state = 0;
        else begin m_state = 3; m_hold = 0; end
      end else begin
        m_win.push_back(error);
        if (m_win.size() == 64) begin
          tot = 0; ld = 0; lg = 0;
          foreach (m_win[i]) begin
            if (m_win[i] != 2'b00) tot++;
            if (m_win[i] == 2'b11) ld++;
            if (m_win[i] == 2'b01) lg++;
          end
          m_win.delete();
          m_ec   = tot;
          m_bias = (ld > lg) ? 2'b11 : (lg > ld) ? 2'b01 : 2'b00;
          m_wd   = 1'b1;
          if (m_state == 1) begin
            if (tot <= 4) begin
              m_good++;
              if (m_good == 4) begin m_state = 2; m_good = 0; m_bad = 0; end
            end else m_good = 0;
          end else begin
            if (tot > 4) begin
              m_bad++;
              if (m_bad == 2) begin m_state = 1; m_good = 0; m_bad = 0; end
            end else m_bad = 0;
          end
        end
      end
      m_locked = (m_state == 2) || (m_state == 3);
    end
  end

  always @(negedge clk)
    chk("model", {18'b0, lock_state, locked, err_count, freq_bias, window_done, cycle_tick},
        {18'b0, 2'(m_state), m_locked, 7'(m_ec), m_bias, m_wd, m_tick});

  task automatic chk_out(input string name, input logic [1:0] st, input logic lk,
                         input int ec, input logic [1:0] bias, input logic wd);
    chk({name, ".state"}, 32'(lock_state), 32'(st));
    chk({name, ".locked"}, 32'(locked), 32'(lk));
    chk({name, ".err_count"}, 32'(err_count), 32'(ec));
    chk({name, ".bias"}, 32'(freq_bias), 32'(bias));
    chk({name, ".wdone"}, 32'(window_done), 32'(wd));
  endtask

  // One 64-cycle window: n_a cycles of code_a, n_b of code_b, rest clean.
  task automatic run_win(input int n_a, input logic [1:0] code_a,
                         input int n_b, input logic [1:0] code_b);
    for (int i = 0; i < 64; i++) begin
      error = (i < n_a) ? code_a : (i < n_a + n_b) ? code_b : 2'b00;
      @(negedge clk);
    end
    error = 2'b00;
  endtask

  task automatic restart();
    nrst = 1'b1; enable = 1'b1; error = 2'b00;
    @(negedge clk);
    nrst = 1'b0;
    @(negedge clk);
  endtask

  typedef struct {
    logic       rst;
    logic       en;
    logic [1:0] err;
    int         cycles;
    logic [1:0] st;
    logic       lk;
    int         ec;
    logic [1:0] bias;
    logic       wd;
  } seg_t;

  seg_t tbl[7];

  initial begin
    int ticks, first_tick, burst, err_pct;
    nrst = 1'b1; enable = 1'b1; error = 2'b11; phase = '0;

    tbl[0] = '{1'b1, 1'b1, 2'b11, 3,   2'b00, 1'b0, 0, 2'b00, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 2'b00, 1,   2'b01, 1'b0, 0, 2'b00, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 2'b00, 63,  2'b01, 1'b0, 0, 2'b00, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 2'b00, 1,   2'b01, 1'b0, 0, 2'b00, 1'b1};
    tbl[4] = '{1'b0, 1'b1, 2'b00, 1,   2'b01, 1'b0, 0, 2'b00, 1'b0};
    tbl[5] = '{1'b0, 1'b1, 2'b00, 190, 2'b01, 1'b0, 0, 2'b00, 1'b0};
    tbl[6] = '{1'b0, 1'b1, 2'b00, 1,   2'b10, 1'b1, 0, 2'b00, 1'b1};
    for (int r = 0; r < 7; r++) begin
      nrst = tbl[r].rst; enable = tbl[r].en; error = tbl[r].err;
      repeat (tbl[r].cycles) @(negedge clk);
      chk_out($sformatf("tbl%0d", r), tbl[r].st, tbl[r].lk, tbl[r].ec, tbl[r].bias, tbl[r].wd);
      chk($sformatf("tbl%0d.tick", r), 32'(cycle_tick), 32'd0);
    end

    // Threshold boundary in acquisition: 4 errors good, 5 errors bad.
    restart();
    for (int w = 0; w < 3; w++) run_win(4, 2'b01, 0, 2'b00);
    chk_out("acq_3good", 2'b01, 1'b0, 4, 2'b01, 1'b1);
    run_win(5, 2'b01, 0, 2'b00);
    chk_out("acq_bad5", 2'b01, 1'b0, 5, 2'b01, 1'b1);
    for (int w = 0; w < 3; w++) run_win(4, 2'b11, 0, 2'b00);
    chk_out("acq_3more", 2'b01, 1'b0, 4, 2'b11, 1'b1);
    run_win(4, 2'b11, 0, 2'b00);
    chk_out("acq_lock", 2'b10, 1'b1, 4, 2'b11, 1'b1);

    // Loss of lock needs two consecutive bad windows.
    run_win(10, 2'b11, 0, 2'b00);
    chk_out("lk_bad1", 2'b10, 1'b1, 10, 2'b11, 1'b1);
    run_win(0, 2'b00, 0, 2'b00);
    chk_out("lk_clean", 2'b10, 1'b1, 0, 2'b00, 1'b1);
    run_win(10, 2'b10, 0, 2'b00);
    chk_out("lk_bad2a", 2'b10, 1'b1, 10, 2'b00, 1'b1);
    run_win(0, 2'b00, 10, 2'b01);
    chk_out("lk_drop", 2'b01, 1'b0, 10, 2'b01, 1'b1);

    // Relock, then hold behaviour.
    for (int w = 0; w < 4; w++) run_win(0, 2'b00, 0, 2'b00);
    chk_out("relock", 2'b10, 1'b1, 0, 2'b00, 1'b1);
    enable = 1'b0;
    repeat (100) @(negedge clk);
    chk_out("hold100", 2'b11, 1'b1, 0, 2'b00, 1'b0);
    enable = 1'b1;
    @(negedge clk);
    chk_out("hold_reen", 2'b10, 1'b1, 0, 2'b00, 1'b0);
    error = 2'b11;
    repeat (63) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    chk_out("win_end_fall", 2'b11, 1'b1, 0, 2'b00, 1'b0);
    enable = 1'b1; error = 2'b00;
    @(negedge clk);
    run_win(0, 2'b00, 0, 2'b00);
    chk_out("win_cleared", 2'b10, 1'b1, 0, 2'b00, 1'b1);
    enable = 1'b0;
    repeat (256) @(negedge clk);
    chk_out("hold256", 2'b11, 1'b1, 0, 2'b00, 1'b0);
    @(negedge clk);
    chk_out("hold_expire", 2'b00, 1'b0, 0, 2'b00, 1'b0);

    // Bias and phase tick.
    restart();
    run_win(3, 2'b11, 1, 2'b01);
    chk_out("bias_lead", 2'b01, 1'b0, 4, 2'b11, 1'b1);
    ticks = 0; first_tick = -1;
    for (int k = 0; k < 64; k++) begin
      phase = 32'(k) << 28;
      @(negedge clk);
      chk($sformatf("tick_k%0d", k), 32'(cycle_tick), 32'((k % 16) == 8));
      if (cycle_tick) begin
        ticks++;
        if (first_tick < 0) first_tick = k;
      end
    end
    chk("tick_count", 32'(ticks), 32'd4);
    chk("tick_first", 32'(first_tick), 32'd8);

    // Randomized traffic; the model comparison runs every cycle.
    burst = 0; err_pct = 0;
    for (int c = 0; c < 24000; c++) begin
      if ((c % 64) == 0) err_pct = $urandom_range(0, 14);
      nrst = ($urandom_range(0, 4999) == 0);
      if (burst > 0) begin
        enable = 1'b0;
        burst--;
      end else begin
        enable = 1'b1;
        if ($urandom_range(0, 399) == 0) burst = $urandom_range(1, 300);
      end
      error = ($urandom_range(0, 99) < err_pct) ? 2'($urandom_range(1, 3)) : 2'b00;
      phase = phase + ($urandom_range(0, 3) == 0 ? $urandom : 32'h0800_0000);
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
